// File: rtl/twid_seq.sv
// twid_seq: FFT twiddle-factor sequencer. On an accepted start it streams the
// N/2 twiddles (cos, sin, exponent) of one radix-2 stage over a valid/ready
// handshake at one beat per cycle. Values come from a quarter-wave cosine ROM
// built at elaboration and folded onto the half circle.
// Optional feature: define TWID_FWD_EN to add the fwd input; with fwd=1 the
// sin output is negated (forward-FFT twiddles). Without it, IFFT twiddles only.
module twid_seq #(
   parameter int LOG2N = 5,
   parameter int WIDTH = 36,
   parameter int FRAC  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       stage,
`ifdef TWID_FWD_EN
   input  logic             fwd,
`endif
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] cos_val,
   output logic [WIDTH-1:0] sin_val,
   output logic [LOG2N-2:0] exp,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int N  = 1 << LOG2N;
   localparam int EW = LOG2N - 1;
   // Exponents live in [0, N/2), so EW-bit arithmetic wraps modulo N/2.
   localparam logic [EW-1:0] QTR_E     = EW'(N / 4);
   localparam logic [EW-1:0] LAST_BEAT = EW'(N / 2 - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Q[k] = round(cos(2*pi*k/N) * 2^FRAC); only k in [0, N/4] is ever used,
   // where the cosine is non-negative, so round-half-up is exact rounding.
   function automatic logic [WIDTH-1:0] quarter_wave(input int k);
      real    ang;
      real    val;
      longint ival;
      ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      val  = $cos(ang) * (2.0 ** FRAC);
      ival = longint'($floor(val + 0.5));
      return ival[WIDTH-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [EW-1:0]    beat_q, beat_d;
   logic [3:0]       stage_q, stage_d;
   logic             fwd_q, fwd_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] cos_q, cos_d;
   logic [WIDTH-1:0] sin_q, sin_d;
   logic [EW-1:0]    exp_q, exp_d;
   logic             last_q, last_d;
   logic             done_q, done_d;

   logic             fwd_in_s;
   logic [WIDTH-1:0] rom_s [N/4+1];
   logic [EW-1:0]    tw_beat_s;
   logic [3:0]       tw_stage_s;
   logic             tw_fwd_s;
   logic [EW-1:0]    tw_mask_s;
   logic [EW-1:0]    tw_exp_s;
   logic [EW-1:0]    cos_idx_s;
   logic [EW-1:0]    sin_idx_s;
   logic             cos_neg_s;
   logic [WIDTH-1:0] tw_cos_s;
   logic [WIDTH-1:0] tw_sin_s;

`ifdef TWID_FWD_EN
   assign fwd_in_s = fwd;
`else
   assign fwd_in_s = 1'b0;
`endif

   for (genvar k = 0; k <= N / 4; k++) begin : g_rom
      assign rom_s[k] = quarter_wave(k);
   end

   // Select which beat the twiddle datapath evaluates: beat 0 of the requested
   // stage while idle, otherwise the beat following the one on the outputs.
   always_comb begin
      if (state_q == IDLE) begin
         tw_beat_s  = '0;
         tw_stage_s = stage;
         tw_fwd_s   = fwd_in_s;
      end else begin
         tw_beat_s  = beat_q + EW'(1'b1);
         tw_stage_s = stage_q;
         tw_fwd_s   = fwd_q;
      end
   end

   // Exponent e = (b mod 2^s) << (LOG2N-1-s), then fold e onto the quarter-wave ROM.
   always_comb begin
      tw_mask_s = EW'((32'd1 << tw_stage_s) - 32'd1);
      tw_exp_s  = (tw_beat_s & tw_mask_s) << (EW - int'(tw_stage_s));
      if (tw_exp_s <= QTR_E) begin
         cos_idx_s = tw_exp_s;
         sin_idx_s = QTR_E - tw_exp_s;
         cos_neg_s = 1'b0;
      end else begin
         // N/2 - e wraps to -e in EW bits.
         cos_idx_s = EW'(1'b0) - tw_exp_s;
         sin_idx_s = tw_exp_s - QTR_E;
         cos_neg_s = 1'b1;
      end
      tw_cos_s = cos_neg_s ? -rom_s[cos_idx_s] : rom_s[cos_idx_s];
      tw_sin_s = tw_fwd_s  ? -rom_s[sin_idx_s] : rom_s[sin_idx_s];
   end

   // Next-state and next-output logic of the IDLE/RUN sequencer.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      stage_d = stage_q;
      fwd_d   = fwd_q;
      valid_d = valid_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      exp_d   = exp_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (int'(stage) < LOG2N)) begin
               state_d = RUN;
               beat_d  = '0;
               stage_d = stage;
               fwd_d   = fwd_in_s;
               valid_d = 1'b1;
               cos_d   = tw_cos_s;
               sin_d   = tw_sin_s;
               exp_d   = tw_exp_s;
               last_d  = (LAST_BEAT == '0);
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (valid_q && out_ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  beat_d  = '0;
                  valid_d = 1'b0;
                  cos_d   = '0;
                  sin_d   = '0;
                  exp_d   = '0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  beat_d  = beat_q + EW'(1'b1);
                  cos_d   = tw_cos_s;
                  sin_d   = tw_sin_s;
                  exp_d   = tw_exp_s;
                  last_d  = ((beat_q + EW'(1'b1)) == LAST_BEAT);
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         stage_q <= 4'd0;
         fwd_q   <= 1'b0;
         valid_q <= 1'b0;
         cos_q   <= '0;
         sin_q   <= '0;
         exp_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         stage_q <= stage_d;
         fwd_q   <= fwd_d;
         valid_q <= valid_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         exp_q   <= exp_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign out_valid = valid_q;
   assign cos_val   = cos_q;
   assign sin_val   = sin_q;
   assign exp       = exp_q;
   assign last      = last_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;

endmodule

// File: tb/tb_twid_seq.sv
// tb_twid_seq: self-checking bench for twid_seq (LOG2N=5, WIDTH=36, FRAC=32).
// A scoreboard queue holds expected beats computed from real-valued cos/sin;
// a constant table checks selected beats; hand sequences cover stalls,
// ignored starts, mid-run reset and restart.
module tb_twid_seq;

   localparam int  LOG2N = 5;
   localparam int  W     = 36;
   localparam int  FRAC  = 32;
   localparam int  NN    = 32;
   localparam int  HB    = 16;
   localparam real PI    = 3.14159265358979323846;

   typedef struct {
      logic [3:0]   e;
      logic [W-1:0] c;
      logic [W-1:0] s;
      logic         l;
      int           st;
      int           b;
   } beat_t;

   typedef struct {
      int           st;
      int           b;
      logic [3:0]   e;
      logic [W-1:0] c;
      logic [W-1:0] s;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   stage;
   logic         fwd;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] cos_val;
   logic [W-1:0] sin_val;
   logic [3:0]   exp_v;
   logic         last;
   logic         busy;
   logic         done;

   int           errors = 0;
   int           checks = 0;
   beat_t        sb[$];
   vec_t         tbl[9];
   logic [W-1:0] cap_c [5][HB];
   logic [W-1:0] cap_s [5][HB];
   logic [3:0]   cap_e [5][HB];

   always #5 clk = ~clk;

   twid_seq #(.LOG2N(LOG2N), .WIDTH(W), .FRAC(FRAC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stage     (stage),
`ifdef TWID_FWD_EN
      .fwd       (fwd),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .cos_val   (cos_val),
      .sin_val   (sin_val),
      .exp       (exp_v),
      .last      (last),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   function automatic logic [W-1:0] rnd_w(input real x);
      real    r;
      longint v;
      if (x >= 0.0) r = $floor(x + 0.5);
      else          r = -$floor(-x + 0.5);
      v = longint'(r);
      return v[W-1:0];
   endfunction

   function automatic int exp_of(input int st, input int b);
      return (b % (1 << st)) * (NN >> (st + 1));
   endfunction

   // Drives start at the current negedge, pushes the expected stage into the
   // scoreboard and drains it. Optional: stall, ignored start, start on the
   // last beat, reset abort (-1 disables an option).
   task automatic run_stage(input int st, input bit fw, input int stall_beat, input int stall_len,
                            input int poke_beat, input bit last_start, input int abort_beat);
      beat_t it;
      real   ang;
      real   two_f;
      int    e;
      int    nb;
      int    cyc;
      int    stall;
      bit    aborted;
      two_f = 2.0 ** FRAC;
      for (int b = 0; b < HB; b++) begin
         e     = exp_of(st, b);
         ang   = 2.0 * PI * real'(e) / real'(NN);
         it.e  = 4'(e);
         it.c  = rnd_w($cos(ang) * two_f);
         it.s  = fw ? rnd_w(-$sin(ang) * two_f) : rnd_w($sin(ang) * two_f);
         it.l  = (b == HB - 1);
         it.st = st;
         it.b  = b;
         sb.push_back(it);
      end
      fwd   = fw;
      start = 1'b1;
      stage = 4'(st);
      @(negedge clk);
      start = 1'b0;
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("busy_run", 64'(busy), 64'd1);
      nb = 0; cyc = 0; stall = 0; aborted = 1'b0;
      while (nb < HB && cyc < 100) begin
         if (nb == abort_beat) begin
            rst_n = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_last", 64'(last), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_cos", 64'(cos_val), 64'd0);
            chk("rst_sin", 64'(sin_val), 64'd0);
            chk("rst_exp", 64'(exp_v), 64'd0);
            sb.delete();
            rst_n   = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (nb == stall_beat && stall < stall_len) begin
            out_ready = 1'b0;
            stall++;
         end else begin
            out_ready = 1'b1;
         end
         if (nb == poke_beat) begin
            start = 1'b1; stage = 4'd1;
         end else if (last_start && nb == HB - 1) begin
            start = 1'b1; stage = 4'd0;
         end else begin
            start = 1'b0;
         end
         chk("valid_run", 64'(out_valid), 64'd1);
         chk("done_run", 64'(done), 64'd0);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 64'(sb.size()), 64'd1);
            end else begin
               it = sb[0];
               chk($sformatf("exp_s%0d_b%0d", it.st, it.b), 64'(exp_v), 64'(it.e));
               chk($sformatf("cos_s%0d_b%0d", it.st, it.b), 64'(cos_val), 64'(it.c));
               chk($sformatf("sin_s%0d_b%0d", it.st, it.b), 64'(sin_val), 64'(it.s));
               chk($sformatf("last_s%0d_b%0d", it.st, it.b), 64'(last), 64'(it.l));
               if (out_ready) begin
                  cap_c[st][it.b] = cos_val;
                  cap_s[st][it.b] = sin_val;
                  cap_e[st][it.b] = exp_v;
                  void'(sb.pop_front());
                  nb++;
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      if (!aborted) begin
         if (cyc >= 100) begin
            chk("run_timeout", 64'(nb), 64'(HB));
            sb.delete();
         end
         chk("done_pulse", 64'(done), 64'd1);
         chk("valid_end", 64'(out_valid), 64'd0);
         chk("busy_end", 64'(busy), 64'd0);
         @(negedge clk);
         chk("done_once", 64'(done), 64'd0);
         chk("idle_after", 64'(out_valid), 64'd0);
      end
   endtask

   initial begin
      tbl[0] = '{0, 0,  4'd0,  36'h100000000, 36'h000000000};
      tbl[1] = '{0, 15, 4'd0,  36'h100000000, 36'h000000000};
      tbl[2] = '{1, 1,  4'd8,  36'h000000000, 36'h100000000};
      tbl[3] = '{1, 2,  4'd0,  36'h100000000, 36'h000000000};
      tbl[4] = '{2, 3,  4'd12, 36'hF4AFB0CCC, 36'h0B504F334};
      tbl[5] = '{3, 4,  4'd8,  36'h000000000, 36'h100000000};
      tbl[6] = '{4, 8,  4'd8,  36'h000000000, 36'h100000000};
      tbl[7] = '{4, 4,  4'd4,  36'h0B504F334, 36'h0B504F334};
      tbl[8] = '{4, 12, 4'd12, 36'hF4AFB0CCC, 36'h0B504F334};

      rst_n = 1'b0; start = 1'b0; stage = 4'd0; fwd = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_last", 64'(last), 64'd0);
      chk("reset_cos", 64'(cos_val), 64'd0);
      chk("reset_sin", 64'(sin_val), 64'd0);
      chk("reset_exp", 64'(exp_v), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_valid", 64'(out_valid), 64'd0);

      run_stage(0, 1'b0, -1, 0, -1, 1'b1, -1);   // start on last beat is ignored
      run_stage(1, 1'b0, -1, 0, -1, 1'b0, -1);
      run_stage(2, 1'b0, -1, 0, 3, 1'b0, -1);    // start mid-run is ignored
      run_stage(3, 1'b0, -1, 0, -1, 1'b0, -1);
      run_stage(4, 1'b0, 5, 3, -1, 1'b0, -1);    // stall 3 cycles at beat 5

      // Out-of-range stages are rejected from IDLE.
      start = 1'b1; stage = 4'd5;
      @(negedge clk);
      start = 1'b1; stage = 4'd15;
      @(negedge clk);
      start = 1'b0;
      chk("stage5_valid", 64'(out_valid), 64'd0);
      chk("stage5_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("stage15_valid", 64'(out_valid), 64'd0);

      run_stage(4, 1'b0, -1, 0, -1, 1'b0, 7);    // reset at beat 7
      run_stage(4, 1'b0, -1, 0, -1, 1'b0, -1);   // restart on first cycle out of reset

      for (int i = 0; i < 9; i++) begin
         chk($sformatf("tbl%0d_exp", i), 64'(cap_e[tbl[i].st][tbl[i].b]), 64'(tbl[i].e));
         chk($sformatf("tbl%0d_cos", i), 64'(cap_c[tbl[i].st][tbl[i].b]), 64'(tbl[i].c));
         chk($sformatf("tbl%0d_sin", i), 64'(cap_s[tbl[i].st][tbl[i].b]), 64'(tbl[i].s));
      end

`ifdef TWID_FWD_EN
      run_stage(4, 1'b1, -1, 0, -1, 1'b0, -1);
      chk("fwd_cos_b4", 64'(cap_c[4][4]), 64'h0B504F334);
      chk("fwd_sin_b4", 64'(cap_s[4][4]), 64'hF4AFB0CCC);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
